// File: rtl/axis_dest_demux.sv
// axis_dest_demux: AXI4-Stream 1-to-M frame demultiplexer.
// The first beat's tdest picks the output port for the whole frame, and
// frames with an out-of-range tdest are swallowed. The output stage is a
// register plus a skid register, so s_axis_tready can be a flop and the
// block still moves one beat per clock.
module axis_dest_demux #(
  parameter int M_COUNT     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
  parameter int ID_ENABLE   = 0,
  parameter int ID_WIDTH    = 8,
  parameter int DEST_WIDTH  = 8,
  parameter int USER_ENABLE = 1,
  parameter int USER_WIDTH  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]         s_axis_tkeep,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  input  logic [ID_WIDTH-1:0]           s_axis_tid,
  input  logic [DEST_WIDTH-1:0]         s_axis_tdest,
  input  logic [USER_WIDTH-1:0]         s_axis_tuser,
  output logic [M_COUNT*DATA_WIDTH-1:0] m_axis_tdata,
  output logic [M_COUNT*KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic [M_COUNT-1:0]            m_axis_tvalid,
  input  logic [M_COUNT-1:0]            m_axis_tready,
  output logic [M_COUNT-1:0]            m_axis_tlast,
  output logic [M_COUNT*ID_WIDTH-1:0]   m_axis_tid,
  output logic [M_COUNT*DEST_WIDTH-1:0] m_axis_tdest,
  output logic [M_COUNT*USER_WIDTH-1:0] m_axis_tuser,
  output logic                          drop_frame
);

  localparam int SEL_W = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;
  // One extra bit so that M_COUNT == 2**DEST_WIDTH still fits.
  localparam logic [DEST_WIDTH:0] DEST_LIMIT = (DEST_WIDTH+1)'(M_COUNT);

  typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_t;

  state_t                r_state;
  logic [SEL_W-1:0]      r_sel;
  logic                  r_s_ready;
  logic                  r_drop;
  logic [M_COUNT-1:0]    r_out_valid;
  logic [M_COUNT-1:0]    r_tmp_valid;
  logic [DATA_WIDTH-1:0] r_out_data, r_tmp_data;
  logic [KEEP_WIDTH-1:0] r_out_keep, r_tmp_keep;
  logic                  r_out_last, r_tmp_last;
  logic [ID_WIDTH-1:0]   r_out_id, r_tmp_id;
  logic [DEST_WIDTH-1:0] r_out_dest, r_tmp_dest;
  logic [USER_WIDTH-1:0] r_out_user, r_tmp_user;

  logic [KEEP_WIDTH-1:0] w_in_keep;
  logic [ID_WIDTH-1:0]   w_in_id;
  logic [USER_WIDTH-1:0] w_in_user;
  logic                  w_accept;
  logic                  w_dest_ok;
  logic [SEL_W-1:0]      w_sel;
  logic [M_COUNT-1:0]    w_onehot;
  logic                  w_fwd;
  logic                  w_drop_last;
  logic                  w_out_free;
  logic                  w_tmp_busy;
  logic                  w_load_tmp;
  logic                  w_load_in;
  logic                  w_store_tmp;
  logic [M_COUNT-1:0]    w_out_valid_next;
  logic [M_COUNT-1:0]    w_tmp_valid_next;

  // Disabled sidebands are forced to their fixed values on entry.
  assign w_in_keep = (KEEP_ENABLE != 0) ? s_axis_tkeep : '1;
  assign w_in_id   = (ID_ENABLE != 0)   ? s_axis_tid   : '0;
  assign w_in_user = (USER_ENABLE != 0) ? s_axis_tuser : '0;

  assign w_accept  = s_axis_tvalid && r_s_ready;
  assign w_dest_ok = ({1'b0, s_axis_tdest} < DEST_LIMIT);
  // Only a frame's first beat steers; later tdest values are payload.
  assign w_sel     = (r_state == IDLE) ? s_axis_tdest[SEL_W-1:0] : r_sel;
  assign w_fwd     = w_accept && ((r_state == ROUTE) || ((r_state == IDLE) && w_dest_ok));
  assign w_drop_last = w_accept && s_axis_tlast &&
                       ((r_state == DROP) || ((r_state == IDLE) && !w_dest_ok));

  generate
    for (genvar gi = 0; gi < M_COUNT; gi++) begin : g_onehot
      assign w_onehot[gi] = (w_sel == SEL_W'(gi));
    end
  endgenerate

  // The output register can take a new beat when empty or when its port drains now.
  assign w_out_free  = !(|r_out_valid) || (|(r_out_valid & m_axis_tready));
  assign w_tmp_busy  = |r_tmp_valid;
  assign w_load_tmp  = w_out_free && w_tmp_busy;
  assign w_load_in   = w_out_free && !w_tmp_busy && w_fwd;
  assign w_store_tmp = !w_out_free && w_fwd;

  // Next-state of the output and skid valid flags; the skid always empties first to keep order.
  always_comb begin
    w_out_valid_next = r_out_valid;
    w_tmp_valid_next = r_tmp_valid;
    if (w_out_free) begin
      if (w_tmp_busy) begin
        w_out_valid_next = r_tmp_valid;
        w_tmp_valid_next = '0;
      end else if (w_fwd) begin
        w_out_valid_next = w_onehot;
      end else begin
        w_out_valid_next = '0;
      end
    end else if (w_fwd) begin
      w_tmp_valid_next = w_onehot;
    end
  end

  // Frame FSM: latch the port on the first beat, hold it until tlast, flag dropped frames.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_drop  <= 1'b0;
    end else begin
      r_drop <= w_drop_last;
      if (w_accept) begin
        case (r_state)
          IDLE: begin
            r_sel <= s_axis_tdest[SEL_W-1:0];
            if (!s_axis_tlast) r_state <= w_dest_ok ? ROUTE : DROP;
          end
          ROUTE, DROP: if (s_axis_tlast) r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // Valid flags and the registered ready; ready is low exactly while the skid holds a beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= '0;
      r_tmp_valid <= '0;
      r_s_ready   <= 1'b0;
    end else begin
      r_out_valid <= w_out_valid_next;
      r_tmp_valid <= w_tmp_valid_next;
      r_s_ready   <= !(|w_tmp_valid_next);
    end
  end

  // Payload registers need no reset; their valid flags qualify them.
  always_ff @(posedge clk) begin
    if (w_load_tmp) begin
      r_out_data <= r_tmp_data;
      r_out_keep <= r_tmp_keep;
      r_out_last <= r_tmp_last;
      r_out_id   <= r_tmp_id;
      r_out_dest <= r_tmp_dest;
      r_out_user <= r_tmp_user;
    end else if (w_load_in) begin
      r_out_data <= s_axis_tdata;
      r_out_keep <= w_in_keep;
      r_out_last <= s_axis_tlast;
      r_out_id   <= w_in_id;
      r_out_dest <= s_axis_tdest;
      r_out_user <= w_in_user;
    end
    if (w_store_tmp) begin
      r_tmp_data <= s_axis_tdata;
      r_tmp_keep <= w_in_keep;
      r_tmp_last <= s_axis_tlast;
      r_tmp_id   <= w_in_id;
      r_tmp_dest <= s_axis_tdest;
      r_tmp_user <= w_in_user;
    end
  end

  assign s_axis_tready = r_s_ready;
  assign m_axis_tvalid = r_out_valid;
  assign drop_frame    = r_drop;

  generate
    for (genvar gi = 0; gi < M_COUNT; gi++) begin : g_fanout
      assign m_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH] = r_out_data;
      assign m_axis_tkeep[gi*KEEP_WIDTH +: KEEP_WIDTH] = r_out_keep;
      assign m_axis_tlast[gi]                          = r_out_last;
      assign m_axis_tid[gi*ID_WIDTH +: ID_WIDTH]       = r_out_id;
      assign m_axis_tdest[gi*DEST_WIDTH +: DEST_WIDTH] = r_out_dest;
      assign m_axis_tuser[gi*USER_WIDTH +: USER_WIDTH] = r_out_user;
    end
  endgenerate

endmodule

// File: doc/axis_dest_demux.md
# axis_dest_demux

Single-input, multi-output AXI4-Stream demultiplexer that steers whole frames to one of M_COUNT master ports selected by the first beat's tdest. It is the fan-out counterpart to the arbitrated mux: it sits downstream of a shared stream, for example after the arbitrated mux or a network ingress, and spreads frames to per-destination consumers. Frames with out-of-range tdest are dropped whole. A registered output stage with a skid buffer provides full throughput and registered s_axis_tready.

## Interface
- M_COUNT, 4: number of master ports (2..16).
- DATA_WIDTH, 8: tdata width.
- KEEP_ENABLE, (DATA_WIDTH>8): tkeep is carried when 1; otherwise m tkeep is driven all-ones.
- KEEP_WIDTH, (DATA_WIDTH/8): tkeep width.
- ID_ENABLE, 0 / ID_WIDTH, 8: tid carry enable and width; tid is driven 0 when disabled.
- DEST_WIDTH, 8: tdest width; must be ≥ $clog2(M_COUNT).
- USER_ENABLE, 1 / USER_WIDTH, 1: tuser carry enable and width; tuser is driven 0 when disabled.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  reset; one clock domain, reset is synchronous and active-low.
- s_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser: slave stream; tready is an output, the rest are inputs; widths are per the parameters.
- m_axis_tdata  out  M_COUNT*DATA_WIDTH  per-port data; all slices carry the same value.
- m_axis_tkeep/tlast/tid/tdest/tuser: out, M_COUNT× the respective width, replicated in the same way.
- m_axis_tvalid  out  M_COUNT  one-hot or zero.
- m_axis_tready  in  M_COUNT  per-port ready.
- drop_frame  out  1  one-cycle pulse when the tlast beat of a dropped frame is accepted.

## Operation
- State machine: IDLE, ROUTE, DROP.
- IDLE: on an accepted beat (s tvalid&&tready), the select logic evaluates tdest.
  - If tdest < M_COUNT: sel is set to tdest[$clog2(M_COUNT)-1:0] and the beat is forwarded.
  - Otherwise the beat is discarded.
  - Next state: if the beat has tlast, stay in IDLE; else go to ROUTE or DROP.
- ROUTE: sel is held. tdest on later beats is ignored for routing but is passed through unchanged. The accepted tlast beat returns the FSM to IDLE.
- DROP: beats are accepted and discarded. s_axis_tready follows the normal skid rule, so no stall is added by the drop itself. The accepted tlast beat returns the FSM to IDLE and pulses drop_frame. A single-beat invalid frame also pulses drop_frame.
- Datapath has two stages:
  - Output register: data, sidebands, and one-hot valid.
  - Temp (skid) register, used when the output register is full and not draining.
- s_axis_tready is registered and equals (next cycle) NOT temp_valid.
- Beat order is strictly preserved. No beat is ever duplicated or sent to two ports.
- A stall on the selected port backpressures the input only. Other ports stay idle and are not serviced out of order.

## Timing
- Reset (rst_n=0 at a clk edge) clears:
  - m_axis_tvalid to 0, drop_frame to 0, s_axis_tready to 0.
  - FSM to IDLE, temp_valid to 0.
  - Data registers are don't-care.
- First cycle after reset release: s_axis_tready=1.
- Latency: a beat accepted at edge N appears on m_axis_* after edge N, i.e. one cycle.
- Throughput: 1 beat/clk when the selected m_axis_tready is held high, including back-to-back frames to different ports with no idle cycle.
- Backpressure:
  - Output full and its tready low: the next accepted beat goes to temp, and s_axis_tready drops the cycle after.
  - When the output drains, temp moves to the output and s_axis_tready reasserts the following cycle.
  - m_axis_tvalid, once high, holds with stable data until that port's tready is seen.
- drop_frame asserts the cycle after the dropping tlast beat is accepted, for exactly one cycle.
- Reset mid-frame: all buffered beats are discarded without being presented. The first beat after reset is treated as a frame start.
- Valid flags, FSM, and drop_frame respond only to rst_n sampled at clk. No asynchronous paths.

## Test plan
- Single 4-beat frame tdest=2, data 0x10..0x13, all m tready=1: appears only on port 2, starting 1 cycle after the first accept. tlast is on 0x13. Other tvalids stay 0.
- Back-to-back frames (tdest=0, 3 beats), then (tdest=3, 2 beats), continuous tvalid/tready: 5 output beats in 5 consecutive cycles, with port 0 then port 3 and no bubble.
- Frame tdest=7 (M_COUNT=4), 3 beats, then tdest=1, 1 beat:
  - The first frame is consumed at 1 beat/clk with no m tvalid.
  - drop_frame pulses once.
  - The 1-beat frame appears on port 1.
- tdest changes to 3 on beat 2 of a tdest=1 frame: all beats appear on port 1, and beat 2's m tdest reads 3.
- m_axis_tready[1] toggled 1-0-0-1 during a 6-beat tdest=1 frame: s_axis_tready falls after the skid fills. All 6 beats arrive in order, with no loss or duplication.
- rst_n pulled low for 1 cycle mid-frame, after 2 of 4 beats:
  - All m tvalid are 0 the next cycle, and s_axis_tready=0.
  - The subsequent tdest=0 beat routes to port 0 as a new frame.
